// File: rtl/hazard_forward_ctrl_if.sv
// hazard_forward_ctrl_if: ID-stage tags, memory/flush status and EX-stage forwarding bus for the hazard controller
// master: pipeline side, drives id_* tags, mem_busy, flush, mem_alu_result, wb_data
// slave: controller side, drives forward_a/b, rs1_sel/rs2_sel, stall_if_id, hold_back, bubble_ex, stall_cnt
interface hazard_forward_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) ();
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic [RA_W-1:0] id_rd;
    logic            id_we;
    logic            id_is_load;
    logic            mem_busy;
    logic            flush;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] wb_data;
    logic            forward_a;
    logic            forward_b;
    logic [XLEN-1:0] rs1_sel;
    logic [XLEN-1:0] rs2_sel;
    logic            stall_if_id;
    logic            hold_back;
    logic            bubble_ex;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        output mem_busy, flush, mem_alu_result, wb_data,
        input  forward_a, forward_b, rs1_sel, rs2_sel, stall_if_id, hold_back, bubble_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_we, id_is_load,
        input  mem_busy, flush, mem_alu_result, wb_data,
        output forward_a, forward_b, rs1_sel, rs2_sel, stall_if_id, hold_back, bubble_ex, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: load-use bubbles, memory-wait freeze, flush squash, EX bypass selection and stall counter
// clk/rst: core clock, synchronous active-high reset
// bus (slave): ID tags and status in; forward_a/b, rs1_sel/rs2_sel, stall_if_id, hold_back, bubble_ex, stall_cnt out
module hazard_forward_ctrl #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input logic                 clk,
    input logic                 rst,
    hazard_forward_ctrl_if.slave bus
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } tag_t;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            u1;
        logic            u2;
    } src_t;

    tag_t             r_ex, r_mem, r_wb, w_id;
    src_t             r_src, w_id_src;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt;

    state_t           w_state;
    logic             w_adv, w_flush_eff, w_lu, w_stall, w_bubble;
    logic             w_m1, w_w1, w_m2, w_w2, w_fa, w_fb;
    logic [XLEN-1:0]  w_rs1_sel, w_rs2_sel;

    // The wait state follows mem_busy in the same cycle so the freeze lands on the edge it is sampled.
    always_comb begin
        w_state     = bus.mem_busy ? MEM_WAIT : RUN;
        w_adv       = w_state == RUN;
        w_flush_eff = bus.flush | r_flush_pend;
        w_id        = '{v: bus.id_valid, rd: bus.id_rd, we: bus.id_we, ld: bus.id_is_load};
        w_id_src    = '{rs1: bus.id_rs1, rs2: bus.id_rs2, u1: bus.id_use_rs1, u2: bus.id_use_rs2};
        w_lu        = bus.id_valid & r_ex.v & r_ex.ld & r_ex.we & (r_ex.rd != '0)
                    & ((bus.id_use_rs1 & (bus.id_rs1 == r_ex.rd)) | (bus.id_use_rs2 & (bus.id_rs2 == r_ex.rd)));
        // A squashed instruction never stalls; the flush bubble covers it.
        w_stall     = !w_adv | (w_lu & !w_flush_eff);
        w_bubble    = w_adv & (w_lu | w_flush_eff);
        w_m1        = r_mem.v & r_mem.we & (r_mem.rd != '0) & r_src.u1 & (r_src.rs1 == r_mem.rd);
        w_w1        = r_wb.v & r_wb.we & (r_wb.rd != '0) & r_src.u1 & (r_src.rs1 == r_wb.rd);
        w_m2        = r_mem.v & r_mem.we & (r_mem.rd != '0) & r_src.u2 & (r_src.rs2 == r_mem.rd);
        w_w2        = r_wb.v & r_wb.we & (r_wb.rd != '0) & r_src.u2 & (r_src.rs2 == r_wb.rd);
        w_fa        = r_ex.v & (w_m1 | w_w1);
        w_fb        = r_ex.v & (w_m2 | w_w2);
        // MEM holds the younger producer, so it wins over WB.
        w_rs1_sel   = !w_fa ? '0 : w_m1 ? bus.mem_alu_result : bus.wb_data;
        w_rs2_sel   = !w_fb ? '0 : w_m2 ? bus.mem_alu_result : bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_src        <= '0;
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_adv) begin
                r_wb  <= r_mem;
                r_mem <= r_ex;
                r_ex  <= (w_lu | w_flush_eff) ? '0 : w_id;
                r_src <= w_id_src;
            end
            // A flush seen during a freeze is remembered until the pipeline next moves.
            r_flush_pend <= w_adv ? 1'b0 : (r_flush_pend | bus.flush);
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.forward_a   = w_fa;
    assign bus.forward_b   = w_fb;
    assign bus.rs1_sel     = w_rs1_sel;
    assign bus.rs2_sel     = w_rs2_sel;
    assign bus.stall_if_id = w_stall;
    assign bus.hold_back   = !w_adv;
    assign bus.bubble_ex   = w_bubble;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed scenarios plus randomized run against a pipeline-level reference model
module tb_hazard_forward_ctrl;
    localparam int XLEN  = 64;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       we;
        logic       ld;
        logic       u1;
        logic       u2;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ins_t pipe [3];
    logic m_pend;
    int   m_cnt;

    hazard_forward_ctrl_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    hazard_forward_ctrl #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ins_t id_ins();
        return '{v: bus.id_valid, rd: bus.id_rd, rs1: bus.id_rs1, rs2: bus.id_rs2,
                 we: bus.id_we, ld: bus.id_is_load, u1: bus.id_use_rs1, u2: bus.id_use_rs2};
    endfunction

    function automatic logic m_lu();
        ins_t e = pipe[0];
        return bus.id_valid && e.v && e.ld && e.we && e.rd != 0 &&
               ((bus.id_use_rs1 && bus.id_rs1 == e.rd) || (bus.id_use_rs2 && bus.id_rs2 == e.rd));
    endfunction

    // Nearest older writer of rs (MEM before WB) supplies the operand.
    function automatic logic [XLEN:0] m_fwd(input logic use_rs, input logic [4:0] rs);
        if (!pipe[0].v || !use_rs) return '0;
        for (int i = 1; i < 3; i++)
            if (pipe[i].v && pipe[i].we && pipe[i].rd != 0 && pipe[i].rd == rs)
                return {1'b1, (i == 1) ? bus.mem_alu_result : bus.wb_data};
        return '0;
    endfunction

    task automatic tick();
        logic fe, lu, st;
        ins_t nx;
        fe = bus.flush | m_pend;
        lu = m_lu();
        st = bus.mem_busy | (lu & !fe);
        nx = id_ins();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            m_pend = 1'b0;
            m_cnt  = 0;
        end else begin
            if (!bus.mem_busy) begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (lu | fe) ? '0 : nx;
                m_pend  = 1'b0;
            end else begin
                m_pend = m_pend | bus.flush;
            end
            if (st && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic we, input logic ld);
        bus.id_valid   = v;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_is_load = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_busy       = 1'b0;
        bus.flush          = 1'b0;
        bus.mem_alu_result = '0;
        bus.wb_data        = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.mem_busy = 1'b1;
        bus.flush    = 1'b1;
        tick();
        do_reset();
        set_id(1, 3, 4, 1, 1, 5, 1, 1);
        bus.mem_alu_result = 64'h1111;
        bus.wb_data        = 64'h2222;
        #1;
        checks++;
        if ({bus.forward_a, bus.forward_b, bus.stall_if_id, bus.hold_back, bus.bubble_ex} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=00000",
                     {bus.forward_a, bus.forward_b, bus.stall_if_id, bus.hold_back, bus.bubble_ex});
        end
        checks++;
        if (bus.rs1_sel !== '0 || bus.rs2_sel !== '0) begin
            errors++;
            $display("FAIL reset_sel got=%h/%h want=0/0", bus.rs1_sel, bus.rs2_sel);
        end
        checks++;
        if (bus.stall_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d want=0", bus.stall_cnt);
        end
    endtask

    task automatic test_alu_back_to_back();
        do_reset();
        set_id(1, 1, 2, 1, 1, 5, 1, 0);
        tick();
        set_id(1, 5, 6, 1, 1, 8, 1, 0);
        #1;
        checks++;
        if (bus.stall_if_id !== 1'b0 || bus.bubble_ex !== 1'b0) begin
            errors++;
            $display("FAIL alu_no_stall got=%b%b want=00", bus.stall_if_id, bus.bubble_ex);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_alu_result = 64'h1234;
        bus.wb_data        = 64'h5555;
        #1;
        checks++;
        if (bus.forward_a !== 1'b1 || bus.rs1_sel !== 64'h1234) begin
            errors++;
            $display("FAIL alu_fwd_a got=%b/%h want=1/1234", bus.forward_a, bus.rs1_sel);
        end
        checks++;
        if (bus.forward_b !== 1'b0 || bus.rs2_sel !== '0) begin
            errors++;
            $display("FAIL alu_fwd_b got=%b/%h want=0/0", bus.forward_b, bus.rs2_sel);
        end
    endtask

    task automatic test_distance2();
        do_reset();
        set_id(1, 1, 1, 1, 0, 7, 1, 0);
        tick();
        set_id(1, 1, 1, 1, 0, 9, 0, 0);
        tick();
        set_id(1, 7, 7, 0, 1, 10, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_alu_result = 64'h1;
        bus.wb_data        = 64'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.forward_b !== 1'b1 || bus.rs2_sel !== 64'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dist2_fwd_b got=%b/%h want=1/deadbeef", bus.forward_b, bus.rs2_sel);
        end
        checks++;
        if (bus.forward_a !== 1'b0 || bus.rs1_sel !== '0) begin
            errors++;
            $display("FAIL dist2_unused_rs1 got=%b/%h want=0/0", bus.forward_a, bus.rs1_sel);
        end
    endtask

    task automatic test_mem_wb_priority();
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 0);
        tick();
        set_id(1, 3, 0, 1, 0, 12, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_alu_result = 64'd5;
        bus.wb_data        = 64'd9;
        #1;
        checks++;
        if (bus.forward_a !== 1'b1 || bus.rs1_sel !== 64'd5) begin
            errors++;
            $display("FAIL mem_over_wb got=%b/%0d want=1/5", bus.forward_a, bus.rs1_sel);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 2, 0, 1, 0, 4, 1, 1);
        tick();
        set_id(1, 4, 0, 1, 0, 5, 1, 0);
        #1;
        checks++;
        if ({bus.stall_if_id, bus.bubble_ex, bus.hold_back} !== 3'b110) begin
            errors++;
            $display("FAIL lu_stall got=%b want=110", {bus.stall_if_id, bus.bubble_ex, bus.hold_back});
        end
        tick();
        checks++;
        if ({bus.stall_if_id, bus.bubble_ex} !== 2'b00 || bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_one_cycle got=%b cnt=%0d want=00 cnt=1",
                     {bus.stall_if_id, bus.bubble_ex}, bus.stall_cnt);
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_alu_result = 64'h1111;
        bus.wb_data        = 64'hABCD;
        #1;
        checks++;
        if (bus.forward_a !== 1'b1 || bus.rs1_sel !== 64'hABCD) begin
            errors++;
            $display("FAIL lu_wb_fwd got=%b/%h want=1/abcd", bus.forward_a, bus.rs1_sel);
        end
        checks++;
        if (bus.stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_cnt got=%0d want=1", bus.stall_cnt);
        end
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 1, 1, 0, 0, 0, 1, 0);
        tick();
        set_id(1, 0, 0, 1, 1, 6, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_alu_result = 64'h77;
        bus.wb_data        = 64'h88;
        #1;
        checks++;
        if ({bus.forward_a, bus.forward_b} !== 2'b00 || bus.rs1_sel !== '0) begin
            errors++;
            $display("FAIL x0_no_fwd got=%b/%h want=00/0", {bus.forward_a, bus.forward_b}, bus.rs1_sel);
        end
        set_id(1, 1, 0, 1, 0, 0, 1, 1);
        tick();
        set_id(1, 0, 0, 1, 1, 6, 1, 0);
        #1;
        checks++;
        if ({bus.stall_if_id, bus.bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL x0_load_no_stall got=%b want=00", {bus.stall_if_id, bus.bubble_ex});
        end
    endtask

    task automatic test_flush_wait();
        do_reset();
        set_id(1, 1, 1, 0, 0, 10, 1, 0);
        tick();
        set_id(1, 10, 0, 1, 0, 11, 1, 0);
        bus.mem_busy = 1'b1;
        bus.flush    = 1'b1;
        #1;
        checks++;
        if ({bus.hold_back, bus.stall_if_id, bus.bubble_ex} !== 3'b110) begin
            errors++;
            $display("FAIL wait_c1 got=%b want=110", {bus.hold_back, bus.stall_if_id, bus.bubble_ex});
        end
        tick();
        bus.flush = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            #1;
            checks++;
            if ({bus.hold_back, bus.stall_if_id, bus.bubble_ex} !== 3'b110) begin
                errors++;
                $display("FAIL wait_c%0d got=%b want=110", c, {bus.hold_back, bus.stall_if_id, bus.bubble_ex});
            end
            tick();
        end
        bus.mem_busy = 1'b0;
        #1;
        checks++;
        if ({bus.hold_back, bus.stall_if_id, bus.bubble_ex} !== 3'b001) begin
            errors++;
            $display("FAIL wait_release got=%b want=001", {bus.hold_back, bus.stall_if_id, bus.bubble_ex});
        end
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.forward_a, bus.bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL wait_squashed got=%b want=00", {bus.forward_a, bus.bubble_ex});
        end
        checks++;
        if (bus.stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL wait_cnt got=%0d want=3", bus.stall_cnt);
        end
        bus.mem_busy = 1'b1;
        bus.flush    = 1'b1;
        tick();
        bus.flush = 1'b0;
        rst       = 1'b1;
        tick();
        rst          = 1'b0;
        bus.mem_busy = 1'b0;
        #1;
        checks++;
        if (bus.stall_cnt !== '0 || {bus.hold_back, bus.bubble_ex} !== 2'b00) begin
            errors++;
            $display("FAIL mid_rst got cnt=%0d hb=%b want cnt=0 hb=00",
                     bus.stall_cnt, {bus.hold_back, bus.bubble_ex});
        end
    endtask

    task automatic test_random();
        logic           prev_stall, fe, lu, e_stall;
        logic [XLEN:0]  f1, f2;
        logic [4:0]     got, want;
        ins_t           e, m;
        do_reset();
        prev_stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst                = ($urandom_range(0, 199) == 0);
            bus.mem_busy       = ($urandom_range(0, 4) == 0);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.mem_alu_result = {$urandom, $urandom};
            bus.wb_data        = {$urandom, $urandom};
            if (!prev_stall)
                set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                       $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            #1;
            fe      = bus.flush | m_pend;
            lu      = m_lu();
            e_stall = bus.mem_busy | (lu & !fe);
            f1      = m_fwd(pipe[0].u1, pipe[0].rs1);
            f2      = m_fwd(pipe[0].u2, pipe[0].rs2);
            got     = {bus.forward_a, bus.forward_b, bus.stall_if_id, bus.hold_back, bus.bubble_ex};
            want    = {f1[XLEN], f2[XLEN], e_stall, bus.mem_busy, !bus.mem_busy & (lu | fe)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rnd_flags n=%0d got=%b want=%b", n, got, want);
            end
            checks++;
            if (bus.rs1_sel !== f1[XLEN-1:0] || bus.rs2_sel !== f2[XLEN-1:0]) begin
                errors++;
                $display("FAIL rnd_sel n=%0d got=%h/%h want=%h/%h", n, bus.rs1_sel, bus.rs2_sel,
                         f1[XLEN-1:0], f2[XLEN-1:0]);
            end
            checks++;
            if (bus.stall_cnt !== CNT_W'(m_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, bus.stall_cnt, m_cnt);
            end
            e = pipe[0];
            m = pipe[1];
            checks++;
            if (e.v && m.v && m.ld && m.we && m.rd != 0 &&
                ((e.u1 && e.rs1 == m.rd) || (e.u2 && e.rs2 == m.rd))) begin
                errors++;
                $display("FAIL rnd_mem_load_fwd n=%0d rd=%0d", n, m.rd);
            end
            prev_stall = e_stall;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_pend = 1'b0;
        m_cnt  = 0;
        test_reset();
        test_alu_back_to_back();
        test_distance2();
        test_mem_wb_priority();
        test_load_use();
        test_x0();
        test_flush_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Pipeline hazard and forwarding controller for the 5-stage 64-bit core. It keeps its own registered copy of the register tags for the instructions in EX, MEM and WB. It drives forward_a/forward_b and the 64-bit bypass operands rs1_sel/rs2_sel into the EX-stage forwarding mux. It also sequences load-use bubbles, data-memory wait freezes and branch flushes, and keeps a stall performance counter.

Parameters:
XLEN, 64, datapath width of bypass operands
RA_W, 5, register index width
CNT_W, 32, width of stall counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  RA_W  ID source 1 index
id_rs2  in  RA_W  ID source 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  RA_W  ID destination index
id_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
mem_busy  in  1  data memory not ready; pipeline must freeze
flush  in  1  taken branch/jump resolved in EX (1-cycle pulse)
mem_alu_result  in  XLEN  EX/MEM result value
wb_data  in  XLEN  MEM/WB writeback value
forward_a  out  1  select rs1_sel in EX
forward_b  out  1  select rs2_sel in EX
rs1_sel  out  XLEN  bypass value for operand 1
rs2_sel  out  XLEN  bypass value for operand 2
stall_if_id  out  1  hold PC and IF/ID register
hold_back  out  1  freeze ID/EX, EX/MEM, MEM/WB
bubble_ex  out  1  load NOP into ID/EX on this edge
stall_cnt  out  CNT_W  cycles with stall_if_id=1, saturating

Behaviour:
- **Tag slots.** Internal slots EX, MEM and WB each hold {valid, rd, we, is_load}. The EX slot additionally holds {rs1, rs2, use_rs1, use_rs2}.
- **Reset.** All slots are invalid, state=RUN, flush_pend=0 and stall_cnt=0. All outputs read 0 in the cycle following reset.
- **States.**
  - RUN: advance = !mem_busy.
  - MEM_WAIT: entered when mem_busy=1; exited when mem_busy=0 in the same cycle it is sampled.
  - In MEM_WAIT: hold_back=1, stall_if_id=1, bubble_ex=0, and all slots are frozen.
- **Advance edge.** WB<=MEM, MEM<=EX. EX<= invalid if (lu_hazard | flush_eff), else the ID tags.
- **lu_hazard** (combinational): id_valid & EX.valid & EX.is_load & EX.we & EX.rd!=0 & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)).
- **flush_eff** = flush | flush_pend.
  - flush while mem_busy=1 sets flush_pend.
  - flush_pend clears on the next advance edge.
  - flush_eff suppresses lu_hazard, so there is no stall for a squashed instruction.
- **Outputs in RUN.**
  - stall_if_id = lu_hazard & !flush_eff.
  - bubble_ex = lu_hazard | flush_eff.
  - hold_back = 0.
- **Forwarding** is combinational from the EX slot; the same rules apply to operand 2.
  - Match conditions:
    - m1 = MEM.valid & MEM.we & MEM.rd!=0 & EX.use_rs1 & EX.rs1==MEM.rd.
    - w1 = WB.valid & WB.we & WB.rd!=0 & EX.use_rs1 & EX.rs1==WB.rd.
  - forward_a = EX.valid & (m1|w1).
  - rs1_sel = m1 ? mem_alu_result : wb_data. MEM has priority over WB.
  - rs1_sel = 0 when forward_a=0.
  - rd=0 never forwards.
  - The MEM-slot load match case (m1 with MEM.is_load) cannot occur because of the bubble. The bench asserts it never occurs.
- **Forwarding during MEM_WAIT** stays valid from the frozen slots.
- **Simultaneous events.**
  - mem_busy dominates flush and lu_hazard: no slot moves.
  - lu_hazard is re-evaluated after release.
- **stall_cnt** increments on every edge where stall_if_id=1 and saturates at all-ones.
- **rst mid-operation** returns to reset values on the next edge, regardless of state or flush_pend.

Test Plan:
- **ALU back-to-back.** add x5 (EX) then sub uses x5 -> next cycle forward_a=1, rs1_sel=mem_alu_result (e.g. 0x1234). No stall.
- **Distance-2 dependency.** Producer x7 in WB, consumer rs2=x7 in EX, wb_data=0xDEAD_BEEF -> forward_b=1, rs2_sel=0xDEADBEEF.
- **Both MEM and WB write x3.** mem_alu_result=5, wb_data=9 -> rs1_sel=5.
- **Load-use.** ld x4 in EX, ID add uses x4 -> stall_if_id=1 and bubble_ex=1 for exactly 1 cycle, stall_cnt=1. Two cycles later forward from WB with rs1_sel=wb_data.
- **Register x0.** Writer rd=x0, reader rs1=x0 -> forward_a=0, rs1_sel=0. A load to x0 causes no stall.
- **Flush during memory wait.** mem_busy=1 for 3 cycles with a flush pulse in cycle 1 -> hold_back=1 for 3 cycles. On release, EX is loaded invalid and flush_pend clears. rst asserted in a later cycle clears stall_cnt to 0.
